// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, counter width and index helper for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int FRAME_CNT_W = 16;

    // base < n and step <= n, so a single subtraction is enough to wrap
    function automatic int wrap_add(input int base, input int step, input int n);
        int s;
        s = base + step;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and UART transmitter signals of the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_start,
        output tx_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker searching upward from the last grant
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int W = $clog2(N);

    logic [W-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = last;
        any   = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = W'(wrap_add(int'(last), k, N));
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding bytes from several requesters into one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    uart_tx_arbiter_if.master          bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err,
    output logic [FRAME_CNT_W-1:0]     frames_sent
);

    localparam int GW = $clog2(NUM_REQ);
    // BUSY_TIMEOUT counts the tx_start cycle, so WAIT_BUSY lasts BUSY_TIMEOUT-1 cycles (needs BUSY_TIMEOUT >= 2)
    localparam int TW = $clog2(BUSY_TIMEOUT);

    arb_state_t             state;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [GW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   grant_ok;
    logic                   transfer;
    logic [7:0]             sel_byte;
    logic [TW-1:0]          wait_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .last  (grant_id),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // rst_n in the gate keeps req_ready low while reset is held, not just after it
    assign grant_ok      = rst_n && (state == ST_IDLE) && en;
    assign bus.req_ready = grant_ok ? pick_grant : '0;
    assign transfer      = grant_ok && pick_any;
    assign sel_byte      = bus.req_data[{pick_idx, 3'b000} +: 8];
    assign arb_busy      = (state != ST_IDLE);
    assign frames_sent   = frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            grant_id     <= GW'(NUM_REQ - 1);
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
            frame_cnt    <= '0;
        end else begin
            bus.tx_start <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        bus.tx_data  <= sel_byte;
                        grant_id     <= pick_idx;
                        bus.tx_start <= 1'b1;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (wait_cnt == TW'(BUSY_TIMEOUT - 2)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized arbiter bench against a transaction-timing reference model
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = $clog2(N);
    localparam int BT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] grant_id;
    logic         arb_busy;
    logic         timeout_err;
    logic [15:0]  frames_sent;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus_if ();

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bus         (bus_if),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // Model: absolute cycle numbers at which each observable event is due
    int          cyc;
    int          idle_at, start_cyc, to_cyc, done_cyc, busy_lo, busy_hi;
    int          last, nxt_last;
    logic [7:0]  exp_data, nxt_data;
    logic [15:0] exp_frames;
    int          grants[$];
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int rr_next(input logic [N-1:0] v, input int from);
        int p;
        for (int k = 1; k <= N; k++) begin
            p = (from + k) % N;
            if (v[p[W-1:0]]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last       = N - 1;
        exp_data   = 8'h00;
        exp_frames = 16'h0000;
        idle_at    = 0;
        start_cyc  = -1;
        to_cyc     = -1;
        done_cyc   = -1;
        busy_lo    = -1;
        busy_hi    = -2;
        grants.delete();
    endtask

    // uart_mode: 0 mixed answer/silent, 1 always answers, 2 never raises busy
    task automatic check_cycle(input int uart_mode);
        logic [N-1:0] exp_ready;
        int pick, d, b;
        if (cyc == start_cyc) begin
            last     = nxt_last;
            exp_data = nxt_data;
        end
        if (cyc == done_cyc) exp_frames = exp_frames + 16'd1;
        pick      = (cyc >= idle_at && en) ? rr_next(bus_if.req_valid, last) : -1;
        exp_ready = (pick >= 0) ? (N'(1) << pick) : '0;
        chk("req_ready",   32'(bus_if.req_ready), 32'(exp_ready));
        chk("tx_start",    32'(bus_if.tx_start),  32'(cyc == start_cyc));
        chk("tx_data",     32'(bus_if.tx_data),   32'(exp_data));
        chk("grant_id",    32'(grant_id),         32'(last));
        chk("arb_busy",    32'(arb_busy),         32'(cyc < idle_at));
        chk("timeout_err", 32'(timeout_err),      32'(cyc == to_cyc));
        chk("frames_sent", 32'(frames_sent),      32'(exp_frames));
        if (pick >= 0) begin
            grants.push_back(pick);
            nxt_last  = pick;
            nxt_data  = 8'(bus_if.req_data >> (8 * pick));
            start_cyc = cyc + 1;
            if (uart_mode == 2 || (uart_mode == 0 && $urandom_range(0, 4) == 0)) begin
                to_cyc  = cyc + 1 + BT;
                idle_at = to_cyc;
            end else begin
                d        = $urandom_range(1, BT - 1);
                b        = $urandom_range(1, 6);
                busy_lo  = cyc + 1 + d;
                busy_hi  = cyc + d + b;
                done_cyc = cyc + 2 + d + b;
                idle_at  = done_cyc;
            end
        end
    endtask

    // req_mode: 0 random, 1 all valid, 2 none, 3 requester 0 only with 0x55; en_mode: 0 low, 1 high, 2 random
    task automatic run_cycle(input int req_mode, input int uart_mode, input int en_mode);
        @(posedge clk);
        cyc++;
        #1;
        bus_if.tx_busy = (cyc >= busy_lo && cyc <= busy_hi);
        case (req_mode)
            0:       bus_if.req_valid = N'($urandom);
            1:       bus_if.req_valid = '1;
            2:       bus_if.req_valid = '0;
            default: bus_if.req_valid = N'(1);
        endcase
        bus_if.req_data = (req_mode == 3) ? 32'h0000_0055 : $urandom;
        case (en_mode)
            0:       en = 1'b0;
            1:       en = 1'b1;
            default: en = ($urandom_range(0, 7) != 0);
        endcase
        @(negedge clk);
        check_cycle(uart_mode);
    endtask

    // asynchronous reset applied away from any clock edge, released on a falling edge
    task automatic do_reset();
        rst_n          = 1'b0;
        bus_if.tx_busy = 1'b0;
        #1;
        model_reset();
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'(0));
        chk("rst_tx_start",  32'(bus_if.tx_start),  32'(0));
        chk("rst_tx_data",   32'(bus_if.tx_data),   32'(0));
        chk("rst_frames",    32'(frames_sent),      32'(0));
        chk("rst_grant_id",  32'(grant_id),         32'(N - 1));
        chk("rst_arb_busy",  32'(arb_busy),         32'(0));
        chk("rst_timeout",   32'(timeout_err),      32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cycle(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && cyc < idle_at; i++) run_cycle(2, 1, 1);
        chk("drain_idle", 32'(arb_busy), 32'(0));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        rst_n = 1'b1;
        en = 1'b1;
        bus_if.req_valid = N'(1);
        bus_if.req_data  = 32'h0000_0055;
        bus_if.tx_busy   = 1'b0;
        model_reset();
        #2;

        // single request, granted on the first edge after reset release
        do_reset();
        repeat (14) run_cycle(2, 1, 1);
        chk("single_data", 32'(bus_if.tx_data), 32'h55);
        chk("single_frames", 32'(frames_sent), 32'd1);

        // fairness with every requester valid from reset
        bus_if.req_valid = '1;
        do_reset();
        for (int i = 0; i < 200 && exp_frames != 16'd8; i++) run_cycle(1, 1, 1);
        chk("fair_frames", 32'(frames_sent), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("fair_order", 32'((k < grants.size()) ? grants[k] : -1), 32'(k % N));

        // silent transmitter
        drain();
        run_cycle(3, 2, 1);
        repeat (8) run_cycle(2, 2, 1);
        chk("timeout_idle", 32'(arb_busy), 32'(0));

        // enable dropped mid-frame with requests pending
        drain();
        for (int i = 0; i < 40 && !(start_cyc >= 0 && cyc >= start_cyc && cyc < idle_at); i++)
            run_cycle(1, 1, 1);
        repeat (30) run_cycle(1, 1, 0);
        chk("en_gate_idle", 32'(arb_busy), 32'(0));
        chk("en_gate_ready", 32'(bus_if.req_ready), 32'(0));
        repeat (3) run_cycle(1, 1, 1);

        // frame counter wrap
        drain();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        exp_frames = 16'hFFFF;
        run_cycle(3, 1, 1);
        drain();
        chk("wrap_frames", 32'(frames_sent), 32'h0000);

        // reset while waiting for the transmitter to finish
        drain();
        for (int i = 0; i < 40 && !(start_cyc >= 0 && busy_lo > start_cyc && cyc > busy_lo && cyc < done_cyc); i++)
            run_cycle(1, 1, 1);
        chk("mid_frame_busy", 32'(arb_busy), 32'(1));
        do_reset();
        repeat (3) run_cycle(1, 1, 1);
        chk("post_rst_first", 32'((grants.size() > 0) ? grants[0] : -1), 32'(0));

        // randomized traffic
        repeat (1500) run_cycle(0, 0, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
